mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_arb_pick.sv | 36 +++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter: FSM states, requester ids
// and the mapping from a winning requester to its grant state.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_IF = 2'd1,
      GNT_DM = 2'd2
   } arb_state_t;

   typedef enum logic {
      SRC_IF = 1'b0,
      SRC_DM = 1'b1
   } arb_src_t;

   function automatic arb_state_t grant_state(input arb_src_t src);
      arb_state_t st;
      case (src)
         SRC_IF:  st = GNT_IF;
         SRC_DM:  st = GNT_DM;
         default: st = IDLE;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// Fixed dm-over-if priority, or round-robin when MEM_ARBITER_RR_EN is defined.
module arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic     if_req,
   input  logic     dm_req,
`ifdef MEM_ARBITER_RR_EN
   input  arb_src_t last_src,
`endif
   output logic     any_req,
   output arb_src_t winner
);

   // winner selection; only a simultaneous request consults the history
   always_comb begin
      any_req = if_req | dm_req;
      winner  = SRC_IF;
      if (if_req && dm_req) begin
`ifdef MEM_ARBITER_RR_EN
         if (last_src == SRC_IF) begin
            winner = SRC_DM;
         end else begin
            winner = SRC_IF;
         end
`else
         winner = SRC_DM;
`endif
      end else if (dm_req) begin
         winner = SRC_DM;
      end else begin
         winner = SRC_IF;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) arbiter onto a single registered memory bus.
// Define MEM_ARBITER_RR_EN for round-robin arbitration instead of dm priority.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_ack,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [DATA_W/8-1:0] dm_be,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                dm_ack,
   output logic                bus_req,
   output logic                bus_we,
   output logic [DATA_W/8-1:0] bus_be,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic [DATA_W-1:0]   bus_rdata,
   input  logic                bus_ack,
   output logic                if_stall_o,
   output logic                mem_stall_o
);

   localparam int BE_W = DATA_W / 8;

   arb_state_t state_r;
   arb_state_t state_nxt_s;
   logic       any_req_s;
   arb_src_t   winner_s;
   logic       start_s;

`ifdef MEM_ARBITER_RR_EN
   arb_src_t   last_src_r;

   arb_pick u_pick (
      .if_req   (if_req),
      .dm_req   (dm_req),
      .last_src (last_src_r),
      .any_req  (any_req_s),
      .winner   (winner_s)
   );

   // remembers who won the most recent grant for the next tie-break
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_src_r <= SRC_IF;
      end else if (start_s) begin
         last_src_r <= winner_s;
      end
   end
`else
   arb_pick u_pick (
      .if_req   (if_req),
      .dm_req   (dm_req),
      .any_req  (any_req_s),
      .winner   (winner_s)
   );
`endif

   assign start_s = (state_r == IDLE) && any_req_s;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // next-state logic; bus_ack only matters inside a grant state
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               state_nxt_s = grant_state(winner_s);
            end else begin
               state_nxt_s = IDLE;
            end
         end
         GNT_IF, GNT_DM: begin
            if (bus_ack) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // bus registers: loaded once per grant and held until the bus acks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_be    <= {BE_W{1'b0}};
         bus_addr  <= {ADDR_W{1'b0}};
         bus_wdata <= {DATA_W{1'b0}};
      end else if (start_s) begin
         bus_req <= 1'b1;
         if (winner_s == SRC_DM) begin
            bus_we    <= dm_we;
            bus_be    <= dm_be;
            bus_addr  <= dm_addr;
            bus_wdata <= dm_wdata;
         end else begin
            bus_we    <= 1'b0;
            bus_be    <= {BE_W{1'b1}};
            bus_addr  <= if_addr;
            bus_wdata <= {DATA_W{1'b0}};
         end
      end else if ((state_r != IDLE) && bus_ack) begin
         bus_req <= 1'b0;
      end
   end

   assign if_ack      = (state_r == GNT_IF) && bus_ack;
   assign dm_ack      = (state_r == GNT_DM) && bus_ack;
   assign if_rdata    = bus_rdata;
   assign dm_rdata    = bus_rdata;
   assign if_stall_o  = if_req & ~if_ack;
   assign mem_stall_o = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected bus transactions,
// an independent monitor pops and compares them on every if_ack/dm_ack.
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req;
   logic        dm_we;
   logic [3:0]  dm_be;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        bus_req;
   logic        bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        if_stall_o;
   logic        mem_stall_o;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .if_stall_o(if_stall_o), .mem_stall_o(mem_stall_o)
   );

   typedef struct {
      bit          is_dm;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   stall_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push_exp(input bit is_dm, input logic [31:0] addr, input logic we,
                           input logic [3:0] be, input logic [31:0] wdata,
                           input logic [31:0] rdata);
      exp_t e;
      e.is_dm = is_dm; e.addr = addr; e.we = we; e.be = be; e.wdata = wdata; e.rdata = rdata;
      sb_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // monitor: every ack must match the oldest expected transaction
   always @(negedge clk) begin
      if (if_stall_o) stall_cnt++;
      if (if_ack || dm_ack) begin
         if (if_ack && dm_ack) begin
            check("both_acks", 32'd1, 32'd0);
         end else if (sb_q.size() == 0) begin
            check("unexpected_ack", {30'd0, dm_ack, if_ack}, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("ack_src_dm", {31'd0, dm_ack}, {31'd0, e.is_dm});
            check("ack_bus_addr", bus_addr, e.addr);
            check("ack_bus_we", {31'd0, bus_we}, {31'd0, e.we});
            check("ack_bus_be", {28'd0, bus_be}, {28'd0, e.be});
            check("ack_bus_wdata", bus_wdata, e.wdata);
            check("ack_bus_req", {31'd0, bus_req}, 32'd1);
            check("ack_rdata", e.is_dm ? dm_rdata : if_rdata, e.rdata);
         end
      end
   end

   // present one-cycle bus ack with read data in the current cycle
   task automatic ack_now(input logic [31:0] rdata);
      bus_ack   = 1'b1;
      bus_rdata = rdata;
   endtask

   initial begin
      rst_n = 1'b0; if_req = 1'b0; if_addr = 32'd0;
      dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'd0; dm_addr = 32'd0; dm_wdata = 32'd0;
      bus_rdata = 32'd0; bus_ack = 1'b1;

      // reset state, with bus_ack held high to show acks stay low
      tick(); tick();
      check("rst_bus_req", {31'd0, bus_req}, 32'd0);
      check("rst_bus_we", {31'd0, bus_we}, 32'd0);
      check("rst_bus_be", {28'd0, bus_be}, 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_bus_wdata", bus_wdata, 32'd0);
      check("rst_acks", {30'd0, dm_ack, if_ack}, 32'd0);
      bus_ack = 1'b0;
      rst_n = 1'b1;
      tick();

      // S1: single fetch, ack two cycles after bus_req rises
      stall_cnt = 0;
      if_req = 1'b1; if_addr = 32'h100;
      push_exp(1'b0, 32'h100, 1'b0, 4'hF, 32'd0, 32'hDEADBEEF);
      tick();
      check("s1_bus_req", {31'd0, bus_req}, 32'd1);
      check("s1_bus_addr", bus_addr, 32'h100);
      check("s1_bus_we", {31'd0, bus_we}, 32'd0);
      tick();
      check("s1_hold_addr", bus_addr, 32'h100);
      tick();
      ack_now(32'hDEADBEEF);
      tick();
      bus_ack = 1'b0; if_req = 1'b0;
      check("s1_bus_req_drop", {31'd0, bus_req}, 32'd0);
      tick();
      check("s1_stall_cycles", stall_cnt, 32'd3);

      // S2: simultaneous requests, dm write then fetch
      if_req = 1'b1; if_addr = 32'h300;
      dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h200; dm_wdata = 32'h1234;
      push_exp(1'b1, 32'h200, 1'b1, 4'b0011, 32'h1234, 32'hA5A5A5A5);
      push_exp(1'b0, 32'h300, 1'b0, 4'hF, 32'd0, 32'h0BADF00D);
      tick();
      check("s2_dm_first_we", {31'd0, bus_we}, 32'd1);
      check("s2_dm_first_be", {28'd0, bus_be}, 32'h3);
      ack_now(32'hA5A5A5A5);
      tick();
      bus_ack = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      check("s2_idle_gap", {31'd0, bus_req}, 32'd0);
      tick();
      check("s2_if_granted", {31'd0, bus_req}, 32'd1);
      check("s2_if_addr", bus_addr, 32'h300);
      check("s2_if_be", {28'd0, bus_be}, 32'hF);
      ack_now(32'h0BADF00D);
      tick();
      bus_ack = 1'b0; if_req = 1'b0;
      tick();

      // S6: back-to-back dm reads, ack latency 1, req held across the ack
      dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h10;
      push_exp(1'b1, 32'h10, 1'b0, 4'hF, 32'h1234, 32'h11111111);
      push_exp(1'b1, 32'h14, 1'b0, 4'hF, 32'h1234, 32'h22222222);
      tick();
      check("s6_req_1", {31'd0, bus_req}, 32'd1);
      check("s6_addr_1", bus_addr, 32'h10);
      ack_now(32'h11111111);
      tick();
      bus_ack = 1'b0; dm_addr = 32'h14;
      check("s6_req_0", {31'd0, bus_req}, 32'd0);
      tick();
      check("s6_req_1b", {31'd0, bus_req}, 32'd1);
      check("s6_addr_2", bus_addr, 32'h14);
      ack_now(32'h22222222);
      tick();
      bus_ack = 1'b0; dm_req = 1'b0;
      tick();

      // S3: tie after a dm win
      if_req = 1'b1; if_addr = 32'h400;
      dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h500;
`ifdef MEM_ARBITER_RR_EN
      push_exp(1'b0, 32'h400, 1'b0, 4'hF, 32'd0, 32'h33333333);
      push_exp(1'b1, 32'h500, 1'b0, 4'hF, 32'h1234, 32'h44444444);
      tick();
      check("s3_first_addr", bus_addr, 32'h400);
      ack_now(32'h33333333);
      tick();
      bus_ack = 1'b0; if_req = 1'b0;
      tick();
      check("s3_second_addr", bus_addr, 32'h500);
      ack_now(32'h44444444);
      tick();
      bus_ack = 1'b0; dm_req = 1'b0;
`else
      push_exp(1'b1, 32'h500, 1'b0, 4'hF, 32'h1234, 32'h44444444);
      push_exp(1'b0, 32'h400, 1'b0, 4'hF, 32'd0, 32'h33333333);
      tick();
      check("s3_first_addr", bus_addr, 32'h500);
      ack_now(32'h44444444);
      tick();
      bus_ack = 1'b0; dm_req = 1'b0;
      tick();
      check("s3_second_addr", bus_addr, 32'h400);
      ack_now(32'h33333333);
      tick();
      bus_ack = 1'b0; if_req = 1'b0;
`endif
      tick();

      // S4: stray bus_ack in IDLE
      ack_now(32'h55555555);
      #3;
      check("s4_no_ack", {30'd0, dm_ack, if_ack}, 32'd0);
      tick();
      bus_ack = 1'b0;
      check("s4_still_idle", {31'd0, bus_req}, 32'd0);
      tick();
      check("s4_no_grant", {31'd0, bus_req}, 32'd0);

      // S5: reset while in GNT_DM
      dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h40; dm_wdata = 32'h99;
      tick();
      check("s5_granted", {31'd0, bus_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("s5_rst_bus_req", {31'd0, bus_req}, 32'd0);
      check("s5_rst_bus_addr", bus_addr, 32'd0);
      dm_req = 1'b0;
      tick();
      ack_now(32'h66666666);
      #3;
      check("s5_ack_in_rst", {30'd0, dm_ack, if_ack}, 32'd0);
      tick();
      bus_ack = 1'b0;
      rst_n = 1'b1;
      tick();
      ack_now(32'h77777777);
      #3;
      check("s5_late_ack", {30'd0, dm_ack, if_ack}, 32'd0);
      tick();
      bus_ack = 1'b0;
      check("s5_idle_after", {31'd0, bus_req}, 32'd0);
      tick(); tick();

      check("sb_drained", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
